// File: rtl/operand_pair_streamer.sv
// Collects two multi-block operands (N and M) in any interleaving, waits for the
// downstream multiplier to go idle, then streams both operands block-aligned.
module operand_pair_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] n_in,
  input  logic                     n_valid_in,
  output logic                     n_ready_out,
  input  logic [REGISTER_SIZE-1:0] m_in,
  input  logic                     m_valid_in,
  output logic                     m_ready_out,
  input  logic                     ready_in,
  output logic [REGISTER_SIZE-1:0] n_out,
  output logic [REGISTER_SIZE-1:0] m_out,
  output logic                     valid_out,
  output logic                     last_out
);

  localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CNT_W  = $clog2(BLOCKS + 1);
  localparam int ADDR_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [CNT_W-1:0]  BLOCKS_C  = CNT_W'(BLOCKS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCKS - 1);

  typedef enum logic [1:0] {
    ST_LOADING    = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_STREAMING  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_cnt_q, n_cnt_d;
  logic [CNT_W-1:0]   m_cnt_q, m_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;

  logic               n_wr_s, m_wr_s;
  logic               rd_en_s;
  logic [ADDR_W-1:0]  rd_addr_s;

  logic [REGISTER_SIZE-1:0] n_mem [BLOCKS];
  logic [REGISTER_SIZE-1:0] m_mem [BLOCKS];
  logic [REGISTER_SIZE-1:0] n_rd_q, m_rd_q;

  logic                     rd_vld_q, rd_last_q;
  logic [REGISTER_SIZE-1:0] n_out_q, m_out_q;
  logic                     valid_q, last_q;

  assign n_ready_out = (state_q == ST_LOADING) && (n_cnt_q < BLOCKS_C) && !rst_in;
  assign m_ready_out = (state_q == ST_LOADING) && (m_cnt_q < BLOCKS_C) && !rst_in;
  assign n_wr_s      = n_valid_in && n_ready_out;
  assign m_wr_s      = m_valid_in && m_ready_out;

  // Next-state, load counters and read-address sequencing
  always_comb begin
    state_d   = state_q;
    n_cnt_d   = n_cnt_q;
    m_cnt_d   = m_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_en_s   = 1'b0;
    rd_addr_s = '0;
    case (state_q)
      ST_LOADING: begin
        if (n_wr_s) begin
          n_cnt_d = n_cnt_q + CNT_ONE;
        end else begin
          n_cnt_d = n_cnt_q;
        end
        if (m_wr_s) begin
          m_cnt_d = m_cnt_q + CNT_ONE;
        end else begin
          m_cnt_d = m_cnt_q;
        end
        if ((n_cnt_d == BLOCKS_C) && (m_cnt_d == BLOCKS_C)) begin
          state_d  = ST_WAIT_READY;
          rd_cnt_d = '0;
        end else begin
          state_d  = ST_LOADING;
        end
      end
      ST_WAIT_READY: begin
        // Block 0 is fetched in the same cycle ready_in is seen, keeping latency at 2
        if (ready_in) begin
          rd_en_s   = 1'b1;
          rd_addr_s = '0;
          rd_cnt_d  = CNT_ONE;
          state_d   = ST_STREAMING;
        end else begin
          state_d   = ST_WAIT_READY;
        end
      end
      ST_STREAMING: begin
        if (rd_cnt_q < BLOCKS_C) begin
          rd_en_s   = 1'b1;
          rd_addr_s = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d  = rd_cnt_q + CNT_ONE;
        end else begin
          rd_en_s   = 1'b0;
        end
        if (last_q) begin
          state_d  = ST_LOADING;
          n_cnt_d  = '0;
          m_cnt_d  = '0;
          rd_cnt_d = '0;
        end else begin
          state_d  = ST_STREAMING;
        end
      end
      default: begin
        state_d  = ST_LOADING;
        n_cnt_d  = '0;
        m_cnt_d  = '0;
        rd_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_LOADING;
      n_cnt_q  <= '0;
      m_cnt_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      n_cnt_q  <= n_cnt_d;
      m_cnt_q  <= m_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Operand storage: one write and one registered read port per array, no reset
  always_ff @(posedge clk_in) begin
    if (n_wr_s) begin
      n_mem[n_cnt_q[ADDR_W-1:0]] <= n_in;
    end
    if (m_wr_s) begin
      m_mem[m_cnt_q[ADDR_W-1:0]] <= m_in;
    end
    if (rd_en_s) begin
      n_rd_q <= n_mem[rd_addr_s];
      m_rd_q <= m_mem[rd_addr_s];
    end
  end

  // Read-stage tracking and output registers; data forced to zero outside the window
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      n_out_q   <= '0;
      m_out_q   <= '0;
    end else begin
      rd_vld_q  <= rd_en_s;
      rd_last_q <= rd_en_s && (rd_addr_s == LAST_ADDR);
      valid_q   <= rd_vld_q;
      last_q    <= rd_last_q;
      n_out_q   <= rd_vld_q ? n_rd_q : '0;
      m_out_q   <= rd_vld_q ? m_rd_q : '0;
    end
  end

  assign n_out     = n_out_q;
  assign m_out     = m_out_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_operand_pair_streamer.sv
// Self-checking bench: scenario table plus a rule-based cycle model of loading,
// waiting and the fixed-latency output window.
module tb_operand_pair_streamer;
  localparam int RS = 32;
  localparam int BN = 2048;
  localparam int B  = BN / RS;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst_in, n_valid_in, m_valid_in, ready_in;
  logic [RS-1:0] n_in, m_in;
  logic          n_ready_out, m_ready_out, valid_out, last_out;
  logic [RS-1:0] n_out, m_out;

  always #5 clk = ~clk;

  operand_pair_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .n_in(n_in), .n_valid_in(n_valid_in), .n_ready_out(n_ready_out),
    .m_in(m_in), .m_valid_in(m_valid_in), .m_ready_out(m_ready_out),
    .ready_in(ready_in),
    .n_out(n_out), .m_out(m_out), .valid_out(valid_out), .last_out(last_out)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: operands as accepted, counts, and the cycle T of the stream start
  logic [31:0] n_ref [B];
  logic [31:0] m_ref [B];
  int n_got = 0, m_got = 0, t_start = -1, wait_from = -1;
  bit done_op = 0, obs_last = 0;
  int obs_valid = 0, first_valid = -1, rdy_rise = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle(input logic nv, input logic [31:0] nd, input logic mv,
                       input logic [31:0] md, input logic rdy, input logic rst);
    logic ev, el, ern, erm;
    logic [31:0] en, em;
    int idx;
    bit loaded;
    n_valid_in = nv; n_in = nd; m_valid_in = mv; m_in = md;
    ready_in = rdy; rst_in = rst;
    #1;
    ev = 1'b0; el = 1'b0; en = 32'd0; em = 32'd0;
    if (t_start >= 0 && cyc >= t_start + 2 && cyc <= t_start + B + 1) begin
      idx = cyc - t_start - 2;
      ev = 1'b1; en = n_ref[idx]; em = m_ref[idx]; el = (idx == B - 1);
    end
    ern = !rst && (n_got < B);
    erm = !rst && (m_got < B);
    check("valid_out", 32'(valid_out), 32'(ev));
    check("last_out", 32'(last_out), 32'(el));
    check("n_out", n_out, en);
    check("m_out", m_out, em);
    check("n_ready_out", 32'(n_ready_out), 32'(ern));
    check("m_ready_out", 32'(m_ready_out), 32'(erm));
    if (valid_out === 1'b1) begin
      obs_valid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (last_out === 1'b1) obs_last = 1;
    if (rst) begin
      n_got = 0; m_got = 0; t_start = -1; wait_from = -1;
    end else begin
      loaded = (n_got == B) && (m_got == B);
      if (t_start >= 0 && cyc == t_start + B + 1) begin
        n_got = 0; m_got = 0; t_start = -1; wait_from = -1; done_op = 1;
      end else if (loaded) begin
        if (t_start < 0 && rdy) t_start = cyc;
      end else begin
        if (nv && ern) begin n_ref[n_got] = nd; n_got++; end
        if (mv && erm) begin m_ref[m_got] = md; m_got++; end
        if (n_got == B && m_got == B) wait_from = cyc + 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // mode 0 aligned/ready high, 1 N-then-M with gaps, 2 fully random.
  // rst_phase: 0 none, 1 at N count rst_pos, 2 rst_pos cycles into wait, 3 at stream index rst_pos
  task automatic run_op(input int mode, input int stall, input int rst_phase,
                        input int rst_pos, input bit dead);
    logic nv, mv, rdy, rst;
    logic [31:0] nd, md;
    bit loaded;
    done_op = 0; obs_valid = 0; obs_last = 0; first_valid = -1; rdy_rise = -1;
    for (int budget = 0; budget < 4000 && !done_op; budget++) begin
      nv = 1'b0; mv = 1'b0; rst = 1'b0;
      nd = $urandom; md = $urandom;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      loaded = (n_got == B) && (m_got == B);
      if (!loaded) begin
        case (mode)
          0: begin
            nv = 1'b1; mv = 1'b1; nd = 32'(n_got + 1); md = 32'h1000 + 32'(m_got);
          end
          1: begin
            nv = (n_got < B);
            mv = (n_got == B) && ($urandom % 3 != 0);
          end
          default: begin
            nv = 1'($urandom % 2); mv = 1'($urandom % 2);
          end
        endcase
        if (rst_phase == 1 && n_got == rst_pos) rst = 1'b1;
      end else if (t_start < 0) begin
        rdy = (cyc - wait_from >= stall);
        if (mode == 2 && rdy) rdy = ($urandom % 3 == 0);
        if (rst_phase == 2 && cyc - wait_from == rst_pos) rst = 1'b1;
        if (rdy && !rst && rdy_rise < 0) rdy_rise = cyc;
      end else begin
        if (rst_phase == 3 && cyc - t_start - 2 == rst_pos) rst = 1'b1;
      end
      if (dead && loaded) begin
        nv = 1'b1; mv = 1'b1; nd = DEAD; md = DEAD;
      end
      cycle(nv, nd, mv, md, rdy, rst);
      if (rst) done_op = 1;
    end
    check("op_completed", 32'(done_op), 32'd1);
  endtask

  typedef struct {
    int mode; int stall; int rst_phase; int rst_pos; bit dead;
    int exp_valid; bit exp_last; int exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{0, 0,   0, 0,  1'b0, B,  1'b1, 2};   // aligned load
    vecs[1] = '{1, 0,   0, 0,  1'b1, B,  1'b1, 2};   // skewed + ignored inputs
    vecs[2] = '{2, 500, 0, 0,  1'b0, B,  1'b1, 2};   // long ready stall
    vecs[3] = '{2, 3,   3, 60, 1'b0, 61, 1'b0, 2};   // reset mid-stream
    vecs[4] = '{1, 0,   0, 0,  1'b1, B,  1'b1, 2};   // full op after reset
    vecs[5] = '{2, 0,   0, 0,  1'b0, B,  1'b1, 2};   // back-to-back
    vecs[6] = '{2, 0,   1, 50, 1'b0, 0,  1'b0, -1};  // reset mid-load
    vecs[7] = '{1, 10,  2, 4,  1'b0, 0,  1'b0, -1};  // reset mid-wait
    vecs[8] = '{2, 7,   0, 0,  1'b1, B,  1'b1, 2};

    n_valid_in = 1'b0; m_valid_in = 1'b0; n_in = '0; m_in = '0;
    ready_in = 1'b0; rst_in = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    cycle(1'b1, 32'd5, 1'b1, 32'd6, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].mode, vecs[i].stall, vecs[i].rst_phase, vecs[i].rst_pos, vecs[i].dead);
      check($sformatf("vec%0d_valid_count", i), 32'(obs_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_last_seen", i), 32'(obs_last), 32'(vecs[i].exp_last));
      if (vecs[i].exp_lat >= 0)
        check($sformatf("vec%0d_latency", i), 32'(first_valid - rdy_rise), 32'(vecs[i].exp_lat));
    end

    // Held reset during a partial N-only load, then explicit release checks
    for (int k = 0; k < 10; k++) cycle(1'b1, 32'(k), 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'd1, 1'b1, 32'd1, 1'b1, 1'b1);
    check("ready_low_in_rst", 32'({n_ready_out, m_ready_out}), 32'd0);
    cycle(1'b1, 32'd1, 1'b1, 32'd1, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("ready_after_rst", 32'({n_ready_out, m_ready_out}), 32'd3);
    run_op(0, 0, 0, 0, 1'b1);
    check("final_valid_count", 32'(obs_valid), 32'(B));
    check("final_last_seen", 32'(obs_last), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
